truth_table_sequencer: RTL and testbench

Sweep controller for the combinational maxterm-expression blocks (3-input, NFUNC-output evaluators). On a start request it drives the shared X/Y/Z inputs through all 8 combinations in ascending order and waits a settle time at each one. It samples the selected function output into an 8-bit truth vector and publishes that vector with its maxterm mask and maxterm count. It replaces the open-loop simulation sweep with a synthesizable, handshaked sequencer that several test or diagnostic masters can drive.

---
 rtl/truth_table_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//
// Sweeps the shared X/Y/Z inputs of a 3-input, NFUNC-output combinational
// evaluator through indices 0..7 (x is the MSB). At each index the inputs
// are held for SETTLE cycles in SETTLE, then for one cycle in SAMPLE. The
// selected evaluator output is captured on the edge that leaves SAMPLE. When
// index 7 has been captured, the truth vector, its maxterm mask (~truth) and
// the maxterm count are published together on the edge that enters DONE.
//
// Optional feature macro: SWEEP_COMPARE_EN
//   defined   : match is registered as (truth == expected) when results are
//               published. expected is sampled on that same edge.
//   undefined : no comparator is built, match is tied to 0 and expected is
//               ignored. The port list is the same in both builds.
//
// Handshake: start is looked at only in IDLE. In IDLE, start with
// func_sel < NFUNC is accepted, the sweep begins and busy rises. In IDLE,
// start with func_sel >= NFUNC is rejected and err pulses for one cycle.
// start is ignored in every other state, including the DONE cycle, and err
// does not fire for an ignored start. done pulses for one cycle when the
// results are published.
//
// Parameters:
//   NFUNC    number of evaluator outputs on f_in (1..8)
//   SETTLE   cycles the inputs are held before each sample (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any sweep in progress
//   start      sweep request
//   func_sel   index of the f_in bit to sweep; latched when start is accepted
//   expected   reference truth vector for match
//   f_in       evaluator outputs, driven from x/y/z
//   x, y, z    evaluator inputs
//   busy       high while in SETTLE or SAMPLE
//   done       one-cycle pulse when results are published
//   err        one-cycle pulse after a rejected start
//   truth      bit i = F(i) for the last completed sweep
//   maxterms   ~truth
//   nmax       number of maxterms (0..8)
//   match      truth == expected for the last sweep (0 without the comparator)
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int NFUNC  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func_sel,
    input  logic [7:0]       expected,
    input  logic [NFUNC-1:0] f_in,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       truth,
    output logic [7:0]       maxterms,
    output logic [3:0]       nmax,
    output logic             match
);

    localparam logic [3:0] NFUNC_W  = 4'(NFUNC);
    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] fsel_q, fsel_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] shadow_q, shadow_d;
    logic       err_q, err_d;
    logic       publish;
    logic [7:0] f_ext;
    logic [3:0] nmax_d;

    logic [7:0] truth_q;
    logic [7:0] maxterms_q;
    logic [3:0] nmax_q;

    // Widen f_in to 8 bits so that any 3-bit fsel is a legal index. An
    // accepted fsel is always below NFUNC, so the padding is never sampled.
    always_comb begin
        f_ext            = '0;
        f_ext[NFUNC-1:0] = f_in;
    end

    // Next-state logic and sweep datapath.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fsel_d   = fsel_q;
        wait_d   = wait_q;
        shadow_d = shadow_q;
        err_d    = 1'b0;
        publish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ({1'b0, func_sel} < NFUNC_W) begin
                        fsel_d  = func_sel;
                        idx_d   = 3'd0;
                        wait_d  = 4'd0;
                        state_d = S_SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                wait_d = wait_q + 4'd1;
                if (wait_q + 4'd1 == SETTLE_W) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                shadow_d[idx_q] = f_ext[fsel_q];
                if (idx_q == 3'd7) begin
                    // shadow_d already contains bit 7, so the published
                    // vector is complete on this same edge.
                    state_d = S_DONE;
                    publish = 1'b1;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    wait_d  = 4'd0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Maxterm count: the number of zero entries in the finished vector.
    always_comb begin
        nmax_d = '0;
        for (int i = 0; i < 8; i++) begin
            nmax_d = nmax_d + {3'd0, ~shadow_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            fsel_q   <= 3'd0;
            wait_q   <= 4'd0;
            shadow_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fsel_q   <= fsel_d;
            wait_q   <= wait_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Published results change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            truth_q    <= 8'h00;
            maxterms_q <= 8'hFF;
            nmax_q     <= 4'd8;
        end else if (publish) begin
            truth_q    <= shadow_d;
            maxterms_q <= ~shadow_d;
            nmax_q     <= nmax_d;
        end
    end

`ifdef SWEEP_COMPARE_EN
    logic match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else if (publish) begin
            match_q <= (shadow_d == expected);
        end
    end

    assign match = match_q;
`else
    logic unused_expected;

    assign unused_expected = ^expected;
    assign match           = 1'b0;
`endif

    // In IDLE and DONE the evaluator inputs are parked at 000.
    assign busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign x        = busy & idx_q[2];
    assign y        = busy & idx_q[1];
    assign z        = busy & idx_q[0];
    assign truth    = truth_q;
    assign maxterms = maxterms_q;
    assign nmax     = nmax_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Self-checking bench for truth_table_sequencer. Two instances share the
// clock and reset: dut1 uses SETTLE=1 and dut3 uses SETTLE=3. Each instance
// drives an evaluator model built from maxterm expressions. A table of
// directed sweeps is applied in a loop. Results are checked through an
// expected queue. Hand-written sequences cover rejected starts, ignored
// starts, a mid-sweep reset and the longer settle time.
// ---------------------------------------------------------------------------
module tb_truth_table_sequencer;

    localparam int NFUNC = 5;
    localparam int W     = 21;  // {truth, maxterms, nmax, match}

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, start3;
    logic [2:0]       func_sel, func_sel3;
    logic [7:0]       expected, expected3;
    logic [NFUNC-1:0] f_in, f_in3;
    logic             x, y, z, busy, done, err, match;
    logic [7:0]       truth, maxterms;
    logic [3:0]       nmax;
    logic             x3, y3, z3, busy3, done3, err3, match3;
    logic [7:0]       truth3, maxterms3;
    logic [3:0]       nmax3;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [2:0] fs;
        logic [7:0] ex;
        logic [7:0] truth;
        logic [7:0] maxt;
        logic [3:0] nmax;
        logic       m;     // match value when the comparator is built
    } vec_t;

    vec_t vecs[6];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- evaluator model ----------------
    // f0 = PiM(1,5,7), f1 = x^y^z, f2 = PiM(1,2,3,6), f3 = x&y, f4 = ~z
    function automatic logic [NFUNC-1:0] eval(input logic a, input logic b, input logic c);
        logic [NFUNC-1:0] f;
        f[0] = (a | b | ~c) & (~a | b | ~c) & (~a | ~b | ~c);
        f[1] = a ^ b ^ c;
        f[2] = (a | b | ~c) & (a | ~b | c) & (a | ~b | ~c) & (~a | ~b | c);
        f[3] = a & b;
        f[4] = ~c;
        return f;
    endfunction

    always_comb f_in  = eval(x, y, z);
    always_comb f_in3 = eval(x3, y3, z3);

    truth_table_sequencer #(.NFUNC(NFUNC), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
        .expected(expected), .f_in(f_in), .x(x), .y(y), .z(z),
        .busy(busy), .done(done), .err(err), .truth(truth),
        .maxterms(maxterms), .nmax(nmax), .match(match)
    );

    truth_table_sequencer #(.NFUNC(NFUNC), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .func_sel(func_sel3),
        .expected(expected3), .f_in(f_in3), .x(x3), .y(y3), .z(z3),
        .busy(busy3), .done(done3), .err(err3), .truth(truth3),
        .maxterms(maxterms3), .nmax(nmax3), .match(match3)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic cmp_match(input logic m);
`ifdef SWEEP_COMPARE_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    task automatic sb_check(input string name, input logic [W-1:0] act);
        logic [W-1:0] req;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=%0h required=<empty queue>", name, act);
        end else begin
            req = exp_q.pop_front();
            check(name, 32'(act), 32'(req));
        end
    endtask

    // Sweep on dut1: start, step through, expect done 16 edges after E0.
    task automatic run_sweep1(input logic [2:0] fs, input logic [7:0] ex);
        int k;
        func_sel = fs;
        expected = ex;
        start    = 1'b1;
        tick();                       // E0
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        k = 0;
        while (k <= 40 && !done) begin
            if (k < 16) check("xyz_step", 32'({x, y, z}), 32'(k >> 1));
            tick();
            k++;
        end
        check("done_latency", 32'(k), 32'd16);
        check("busy_in_done", 32'(busy), 32'd0);
        sb_check("result", {truth, maxterms, nmax, match});
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int n;

        vecs[0] = '{fs: 3'd0, ex: 8'h5D, truth: 8'h5D, maxt: 8'hA2, nmax: 4'd3, m: 1'b1};
        vecs[1] = '{fs: 3'd2, ex: 8'hB1, truth: 8'hB1, maxt: 8'h4E, nmax: 4'd4, m: 1'b1};
        vecs[2] = '{fs: 3'd2, ex: 8'hB0, truth: 8'hB1, maxt: 8'h4E, nmax: 4'd4, m: 1'b0};
        vecs[3] = '{fs: 3'd1, ex: 8'h00, truth: 8'h96, maxt: 8'h69, nmax: 4'd4, m: 1'b0};
        vecs[4] = '{fs: 3'd3, ex: 8'hC0, truth: 8'hC0, maxt: 8'h3F, nmax: 4'd6, m: 1'b1};
        vecs[5] = '{fs: 3'd4, ex: 8'h55, truth: 8'h55, maxt: 8'hAA, nmax: 4'd4, m: 1'b1};

        rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
        func_sel = 3'd0; func_sel3 = 3'd0; expected = 8'h00; expected3 = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_xyz",      32'({x, y, z}), 32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_err",      32'(err),       32'd0);
        check("rst_truth",    32'(truth),     32'h00);
        check("rst_maxterms", 32'(maxterms),  32'hFF);
        check("rst_nmax",     32'(nmax),      32'd8);
        check("rst_match",    32'(match),     32'd0);
        check("rst_nmax3",    32'(nmax3),     32'd8);

        // Table-driven sweeps
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].truth, vecs[i].maxt, vecs[i].nmax, cmp_match(vecs[i].m)});
            run_sweep1(vecs[i].fs, vecs[i].ex);
        end

        // Rejected start: err for one cycle, nothing else moves
        func_sel = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse",      32'(err),  32'd1);
        check("err_busy",       32'(busy), 32'd0);
        tick();
        check("err_one_cycle",  32'(err),      32'd0);
        check("err_busy2",      32'(busy),     32'd0);
        check("err_truth_hold", 32'(truth),    32'h55);
        check("err_max_hold",   32'(maxterms), 32'hAA);
        check("err_nmax_hold",  32'(nmax),     32'd4);
        func_sel = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse_sel7", 32'(err), 32'd1);

        // Starts during busy and in the DONE cycle are ignored
        tick();
        exp_q.push_back({8'h5D, 8'hA2, 4'd3, cmp_match(1'b1)});
        func_sel = 3'd0; expected = 8'h5D; start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        for (k = 0; k < 5; k++) tick();
        func_sel = 3'd7; start = 1'b1;
        tick();                       // k = 6
        start = 1'b0;
        check("ign_busy_err",  32'(err),  32'd0);
        check("ign_busy_busy", 32'(busy), 32'd1);
        k = 6;
        while (k <= 40 && !done) begin
            tick();
            k++;
        end
        check("ign_done_latency", 32'(k), 32'd16);
        sb_check("ign_result", {truth, maxterms, nmax, match});
        func_sel = 3'd2; start = 1'b1;
        tick();                       // start sampled in DONE
        start = 1'b0;
        check("ign_done_busy", 32'(busy), 32'd0);
        check("ign_done_err",  32'(err),  32'd0);
        count_dones(20, n);
        check("ign_no_extra_done", 32'(n), 32'd0);
        exp_q.push_back({8'hB1, 8'h4E, 4'd4, cmp_match(1'b0)});
        run_sweep1(3'd2, 8'h00);

        // SETTLE=3: each index held 4 cycles, done 32 edges after E0
        exp_q.push_back({8'h96, 8'h69, 4'd4, cmp_match(1'b1)});
        func_sel3 = 3'd1; expected3 = 8'h96; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        k = 0;
        while (k <= 60 && !done3) begin
            if (k < 32) check("s3_xyz_step", 32'({x3, y3, z3}), 32'(k >> 2));
            tick();
            k++;
        end
        check("s3_done_latency", 32'(k), 32'd32);
        sb_check("s3_result", {truth3, maxterms3, nmax3, match3});

        // Mid-sweep reset at E0+7: immediate reset values, no done follows
        tick();
        func_sel = 3'd4; expected = 8'h55; start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        for (k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        check("ar_busy",     32'(busy),      32'd0);
        check("ar_done",     32'(done),      32'd0);
        check("ar_xyz",      32'({x, y, z}), 32'd0);
        check("ar_truth",    32'(truth),     32'h00);
        check("ar_maxterms", 32'(maxterms),  32'hFF);
        check("ar_nmax",     32'(nmax),      32'd8);
        check("ar_match",    32'(match),     32'd0);
        check("ar_truth3",   32'(truth3),    32'h00);
        tick();
        rst_n = 1'b1;
        count_dones(30, n);
        check("ar_no_done", 32'(n),     32'd0);
        check("ar_truth_after", 32'(truth), 32'h00);
        check("ar_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
